// File: rtl/l2_stall_pkg.sv
// ---------------------------------------------------------------------------
// l2_stall_pkg
// Shared types for the L2 global-control register file.
//   flush_state_t : states of the set/way flush walker
//   fwd_slot_t    : one forward-stall slot (valid, ended, awaited MSHR entry)
// The slot entry field is sized for the largest MSHR count this block is
// expected to see; narrower MSHR indices are zero-extended into it.
// ---------------------------------------------------------------------------
package l2_stall_pkg;

   localparam int FWD_ENTRY_BITS = 8;

   typedef enum logic [1:0] {
      FL_IDLE = 2'd0,
      FL_WALK = 2'd1,
      FL_DONE = 2'd2
   } flush_state_t;

   typedef struct packed {
      logic                      valid;
      logic                      ended;
      logic [FWD_ENTRY_BITS-1:0] entry;
   } fwd_slot_t;

endpackage

// File: rtl/l2_stall_ctrl_regs_flush_walker.sv
// ---------------------------------------------------------------------------
// l2_flush_walker
// Walks every (set, way) pair of the L2 once per flush request.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   flush_start            begin a walk (only honoured while idle)
//   flush_step             current set/way handled, advance to the next one
//   flush_active           walker busy (walking or signalling completion)
//   flush_set, flush_way   current position; held while idle
//   flush_done             one-cycle pulse after the last position is stepped
// ---------------------------------------------------------------------------
module l2_flush_walker
   import l2_stall_pkg::*;
#(
   parameter int L2_SETS = 256,
   parameter int L2_WAYS = 8,
   localparam int SET_BITS = $clog2(L2_SETS),
   localparam int WAY_BITS = $clog2(L2_WAYS)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_start,
   input  logic                flush_step,
   output logic                flush_active,
   output logic [SET_BITS-1:0] flush_set,
   output logic [WAY_BITS-1:0] flush_way,
   output logic                flush_done
);

   flush_state_t state, state_next;
   logic         at_last_way;
   logic         at_last_pos;

   // Wrap points are compared against the real counts so that non-power-of-two
   // geometries never visit positions beyond the last set or way.
   assign at_last_way = (flush_way == WAY_BITS'(L2_WAYS - 1));
   assign at_last_pos = at_last_way && (flush_set == SET_BITS'(L2_SETS - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FL_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: a step taken at the final position finishes the walk,
   // and DONE always falls back to IDLE after its single cycle.
   always_comb begin
      state_next = state;
      case (state)
         FL_IDLE: if (flush_start) state_next = FL_WALK;
         FL_WALK: if (flush_step && at_last_pos) state_next = FL_DONE;
         FL_DONE: state_next = FL_IDLE;
         default: state_next = FL_IDLE;
      endcase
   end

   // Output decode: busy for the whole walk including the completion cycle.
   always_comb begin
      flush_active = 1'b0;
      flush_done   = 1'b0;
      case (state)
         FL_WALK: flush_active = 1'b1;
         FL_DONE: begin
            flush_active = 1'b1;
            flush_done   = 1'b1;
         end
         default: ;
      endcase
   end

   // Position counters: cleared on start, advanced way-first on each step,
   // and left untouched on the final step so the last position stays visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_set <= '0;
         flush_way <= '0;
      end else if (state == FL_IDLE && flush_start) begin
         flush_set <= '0;
         flush_way <= '0;
      end else if (state == FL_WALK && flush_step && !at_last_pos) begin
         if (at_last_way) begin
            flush_way <= '0;
            flush_set <= flush_set + SET_BITS'(1);
         end else begin
            flush_way <= flush_way + WAY_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/l2_stall_ctrl_regs.sv
// ---------------------------------------------------------------------------
// l2_stall_ctrl_regs
// L2 global-control register file feeding stall/gating inputs to the request
// arbiter.
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   add_mshr_entry / incr_mshr_cnt    MSHR allocate / free this cycle
//   mshr_i, lmem_wr_en_clear_mshr     lmem write retiring MSHR entry mshr_i
//   set_/clr_ evict_stall, set_conflict, ongoing_atomic   flag controls
//   fwd_stall_alloc, _alloc_entry     request a fwd-stall slot on an entry
//   fwd_stall_release                 per-slot free mask
//   flush_start, flush_step           flush walker controls
//   evict_stall, set_conflict, ongoing_atomic   flag registers
//   mshr_cnt, mshr_cnt_err            free MSHR count and sticky range error
//   fwd_stall, fwd_stall_full         any / all slots valid
//   fwd_stall_alloc_slot              lowest free slot (combinational)
//   fwd_stall_valid, fwd_stall_ended  per-slot state
//   flush_active, flush_set, flush_way, flush_done   walker status
// ---------------------------------------------------------------------------
module l2_stall_ctrl_regs
   import l2_stall_pkg::*;
#(
   parameter int N_MSHR      = 16,
   parameter int N_FWD_STALL = 2,
   parameter int L2_SETS     = 256,
   parameter int L2_WAYS     = 8,
   localparam int MSHR_BITS  = $clog2(N_MSHR),
   localparam int CNT_BITS   = $clog2(N_MSHR + 1),
   localparam int SLOT_BITS  = (N_FWD_STALL > 1) ? $clog2(N_FWD_STALL) : 1,
   localparam int SET_BITS   = $clog2(L2_SETS),
   localparam int WAY_BITS   = $clog2(L2_WAYS)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   add_mshr_entry,
   input  logic                   incr_mshr_cnt,
   input  logic [MSHR_BITS-1:0]   mshr_i,
   input  logic                   lmem_wr_en_clear_mshr,
   input  logic                   set_evict_stall,
   input  logic                   clr_evict_stall,
   input  logic                   set_set_conflict,
   input  logic                   clr_set_conflict,
   input  logic                   set_ongoing_atomic,
   input  logic                   clr_ongoing_atomic,
   input  logic                   fwd_stall_alloc,
   input  logic [MSHR_BITS-1:0]   fwd_stall_alloc_entry,
   input  logic [N_FWD_STALL-1:0] fwd_stall_release,
   input  logic                   flush_start,
   input  logic                   flush_step,
   output logic                   evict_stall,
   output logic                   set_conflict,
   output logic                   ongoing_atomic,
   output logic [CNT_BITS-1:0]    mshr_cnt,
   output logic                   mshr_cnt_err,
   output logic                   fwd_stall,
   output logic                   fwd_stall_full,
   output logic [SLOT_BITS-1:0]   fwd_stall_alloc_slot,
   output logic [N_FWD_STALL-1:0] fwd_stall_valid,
   output logic [N_FWD_STALL-1:0] fwd_stall_ended,
   output logic                   flush_active,
   output logic [SET_BITS-1:0]    flush_set,
   output logic [WAY_BITS-1:0]    flush_way,
   output logic                   flush_done
);

   logic [2:0] flags_q;
   logic [2:0] flag_set;
   logic [2:0] flag_clr;
   logic       alloc_fire;

   // Free-MSHR counter. Simultaneous allocate and free cancel out; an attempt
   // to leave the 0..N_MSHR range is refused and latched as a sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         mshr_cnt     <= CNT_BITS'(N_MSHR);
         mshr_cnt_err <= 1'b0;
      end else if (add_mshr_entry && !incr_mshr_cnt) begin
         if (mshr_cnt == '0) begin
            mshr_cnt_err <= 1'b1;
         end else begin
            mshr_cnt <= mshr_cnt - CNT_BITS'(1);
         end
      end else if (incr_mshr_cnt && !add_mshr_entry) begin
         if (mshr_cnt == CNT_BITS'(N_MSHR)) begin
            mshr_cnt_err <= 1'b1;
         end else begin
            mshr_cnt <= mshr_cnt + CNT_BITS'(1);
         end
      end
   end

   // Flag registers. Masking with the clear vector after OR-ing in the set
   // vector gives clear priority when both arrive together.
   assign flag_set = {set_ongoing_atomic, set_set_conflict, set_evict_stall};
   assign flag_clr = {clr_ongoing_atomic, clr_set_conflict, clr_evict_stall};

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
      end else begin
         flags_q <= (flags_q | flag_set) & ~flag_clr;
      end
   end

   assign evict_stall    = flags_q[0];
   assign set_conflict   = flags_q[1];
   assign ongoing_atomic = flags_q[2];

   // Slot grant: lowest index whose registered valid is clear. Because it looks
   // only at registered state, a slot being released this cycle is still seen
   // as busy and cannot be handed out again until the following cycle.
   always_comb begin
      fwd_stall_alloc_slot = '0;
      for (int i = N_FWD_STALL - 1; i >= 0; i--) begin
         if (!fwd_stall_valid[i]) fwd_stall_alloc_slot = SLOT_BITS'(i);
      end
   end

   assign fwd_stall_full = &fwd_stall_valid;
   assign fwd_stall      = |fwd_stall_valid;
   assign alloc_fire     = fwd_stall_alloc && !fwd_stall_full;

   // One register per slot. Release beats everything; a fresh allocation always
   // starts with ended clear since the retire compare only sees stored entries.
   for (genvar g = 0; g < N_FWD_STALL; g++) begin : g_slot
      fwd_slot_t slot_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            slot_q <= '0;
         end else if (fwd_stall_release[g]) begin
            slot_q.valid <= 1'b0;
            slot_q.ended <= 1'b0;
         end else if (alloc_fire && fwd_stall_alloc_slot == SLOT_BITS'(g)) begin
            slot_q.valid <= 1'b1;
            slot_q.ended <= 1'b0;
            slot_q.entry <= FWD_ENTRY_BITS'(fwd_stall_alloc_entry);
         end else if (slot_q.valid && lmem_wr_en_clear_mshr &&
                      slot_q.entry == FWD_ENTRY_BITS'(mshr_i)) begin
            slot_q.ended <= 1'b1;
         end
      end

      assign fwd_stall_valid[g] = slot_q.valid;
      assign fwd_stall_ended[g] = slot_q.ended;
   end

   l2_flush_walker #(
      .L2_SETS (L2_SETS),
      .L2_WAYS (L2_WAYS)
   ) u_flush_walker (
      .clk          (clk),
      .rst          (rst),
      .flush_start  (flush_start),
      .flush_step   (flush_step),
      .flush_active (flush_active),
      .flush_set    (flush_set),
      .flush_way    (flush_way),
      .flush_done   (flush_done)
   );

endmodule

// File: tb/tb_l2_stall_ctrl_regs.sv
// ---------------------------------------------------------------------------
// tb_l2_stall_ctrl_regs
// Directed bench for the L2 global-control register file, built with a small
// 4-set x 2-way flush geometry so the whole walk fits in a few cycles.
// ---------------------------------------------------------------------------
module tb_l2_stall_ctrl_regs;

   localparam int N_MSHR      = 16;
   localparam int N_FWD_STALL = 2;
   localparam int L2_SETS     = 4;
   localparam int L2_WAYS     = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       add_mshr_entry, incr_mshr_cnt;
   logic [3:0] mshr_i;
   logic       lmem_wr_en_clear_mshr;
   logic       set_evict_stall, clr_evict_stall;
   logic       set_set_conflict, clr_set_conflict;
   logic       set_ongoing_atomic, clr_ongoing_atomic;
   logic       fwd_stall_alloc;
   logic [3:0] fwd_stall_alloc_entry;
   logic [1:0] fwd_stall_release;
   logic       flush_start, flush_step;
   logic       evict_stall, set_conflict, ongoing_atomic;
   logic [4:0] mshr_cnt;
   logic       mshr_cnt_err;
   logic       fwd_stall, fwd_stall_full;
   logic [0:0] fwd_stall_alloc_slot;
   logic [1:0] fwd_stall_valid, fwd_stall_ended;
   logic       flush_active;
   logic [1:0] flush_set;
   logic [0:0] flush_way;
   logic       flush_done;

   int checks   = 0;
   int failures = 0;

   l2_stall_ctrl_regs #(
      .N_MSHR      (N_MSHR),
      .N_FWD_STALL (N_FWD_STALL),
      .L2_SETS     (L2_SETS),
      .L2_WAYS     (L2_WAYS)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .add_mshr_entry        (add_mshr_entry),
      .incr_mshr_cnt         (incr_mshr_cnt),
      .mshr_i                (mshr_i),
      .lmem_wr_en_clear_mshr (lmem_wr_en_clear_mshr),
      .set_evict_stall       (set_evict_stall),
      .clr_evict_stall       (clr_evict_stall),
      .set_set_conflict      (set_set_conflict),
      .clr_set_conflict      (clr_set_conflict),
      .set_ongoing_atomic    (set_ongoing_atomic),
      .clr_ongoing_atomic    (clr_ongoing_atomic),
      .fwd_stall_alloc       (fwd_stall_alloc),
      .fwd_stall_alloc_entry (fwd_stall_alloc_entry),
      .fwd_stall_release     (fwd_stall_release),
      .flush_start           (flush_start),
      .flush_step            (flush_step),
      .evict_stall           (evict_stall),
      .set_conflict          (set_conflict),
      .ongoing_atomic        (ongoing_atomic),
      .mshr_cnt              (mshr_cnt),
      .mshr_cnt_err          (mshr_cnt_err),
      .fwd_stall             (fwd_stall),
      .fwd_stall_full        (fwd_stall_full),
      .fwd_stall_alloc_slot  (fwd_stall_alloc_slot),
      .fwd_stall_valid       (fwd_stall_valid),
      .fwd_stall_ended       (fwd_stall_ended),
      .flush_active          (flush_active),
      .flush_set             (flush_set),
      .flush_way             (flush_way),
      .flush_done            (flush_done)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it before anything is
   // sampled or re-driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Return every input to its idle value.
   task automatic applyStimulus();
      add_mshr_entry        = 1'b0;
      incr_mshr_cnt         = 1'b0;
      mshr_i                = '0;
      lmem_wr_en_clear_mshr = 1'b0;
      set_evict_stall       = 1'b0;
      clr_evict_stall       = 1'b0;
      set_set_conflict      = 1'b0;
      clr_set_conflict      = 1'b0;
      set_ongoing_atomic    = 1'b0;
      clr_ongoing_atomic    = 1'b0;
      fwd_stall_alloc       = 1'b0;
      fwd_stall_alloc_entry = '0;
      fwd_stall_release     = '0;
      flush_start           = 1'b0;
      flush_step            = 1'b0;
   endtask

   // One comparison: counts it, and on a mismatch counts the failure and
   // reports the tag with observed and expected values.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence with hand-computed expectations.
   initial begin
      applyStimulus();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state.
      checkOutput("rst_cnt",    32'(mshr_cnt), 32'd16);
      checkOutput("rst_err",    32'(mshr_cnt_err), 32'd0);
      checkOutput("rst_flags",  32'({ongoing_atomic, set_conflict, evict_stall}), 32'd0);
      checkOutput("rst_valid",  32'(fwd_stall_valid), 32'd0);
      checkOutput("rst_fstall", 32'(fwd_stall), 32'd0);
      checkOutput("rst_active", 32'(flush_active), 32'd0);

      // Sixteen allocations drain the counter; the seventeenth is refused.
      add_mshr_entry = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      checkOutput("cnt_empty", 32'(mshr_cnt), 32'd0);
      checkOutput("err_before_under", 32'(mshr_cnt_err), 32'd0);
      tick();
      checkOutput("cnt_under_hold", 32'(mshr_cnt), 32'd0);
      checkOutput("err_under", 32'(mshr_cnt_err), 32'd1);
      add_mshr_entry = 1'b0;
      incr_mshr_cnt  = 1'b1;
      tick();
      checkOutput("cnt_incr", 32'(mshr_cnt), 32'd1);
      add_mshr_entry = 1'b1;
      tick();
      checkOutput("cnt_add_incr", 32'(mshr_cnt), 32'd1);
      applyStimulus();

      // Flags: set, then set+clear together where clear must win.
      set_evict_stall    = 1'b1;
      set_ongoing_atomic = 1'b1;
      tick();
      checkOutput("flags_set", 32'({ongoing_atomic, set_conflict, evict_stall}), 32'b101);
      clr_evict_stall  = 1'b1;
      set_set_conflict = 1'b1;
      clr_set_conflict = 1'b1;
      set_evict_stall  = 1'b0;
      tick();
      checkOutput("flags_clr_prio", 32'({ongoing_atomic, set_conflict, evict_stall}), 32'b100);
      applyStimulus();
      clr_ongoing_atomic = 1'b1;
      tick();
      checkOutput("flags_clr", 32'({ongoing_atomic, set_conflict, evict_stall}), 32'b000);
      applyStimulus();

      // Fill both slots with entries 5 and 9.
      fwd_stall_alloc       = 1'b1;
      fwd_stall_alloc_entry = 4'd5;
      #1;
      checkOutput("slot_grant0", 32'(fwd_stall_alloc_slot), 32'd0);
      tick();
      fwd_stall_alloc_entry = 4'd9;
      #1;
      checkOutput("slot_grant1", 32'(fwd_stall_alloc_slot), 32'd1);
      tick();
      checkOutput("valid_11", 32'(fwd_stall_valid), 32'b11);
      checkOutput("full", 32'(fwd_stall_full), 32'd1);
      // A third allocation while full is dropped: retiring its entry later
      // must not mark anything ended.
      fwd_stall_alloc_entry = 4'd12;
      tick();
      checkOutput("drop_valid", 32'(fwd_stall_valid), 32'b11);
      applyStimulus();
      lmem_wr_en_clear_mshr = 1'b1;
      mshr_i                = 4'd12;
      tick();
      checkOutput("drop_no_end", 32'(fwd_stall_ended), 32'b00);
      mshr_i = 4'd9;
      tick();
      checkOutput("ended_10", 32'(fwd_stall_ended), 32'b10);
      applyStimulus();

      // Release slot 0 with an alloc in the same cycle: slot 0 stays free.
      fwd_stall_release     = 2'b01;
      fwd_stall_alloc       = 1'b1;
      fwd_stall_alloc_entry = 4'd3;
      tick();
      checkOutput("rel_alloc_valid", 32'(fwd_stall_valid), 32'b10);
      checkOutput("rel_alloc_ended", 32'(fwd_stall_ended), 32'b10);
      fwd_stall_release = 2'b00;
      #1;
      checkOutput("regrant0", 32'(fwd_stall_alloc_slot), 32'd0);
      tick();
      checkOutput("realloc_valid", 32'(fwd_stall_valid), 32'b11);
      checkOutput("realloc_ended", 32'(fwd_stall_ended), 32'b10);
      applyStimulus();
      lmem_wr_en_clear_mshr = 1'b1;
      mshr_i                = 4'd3;
      tick();
      checkOutput("ended_3", 32'(fwd_stall_ended), 32'b11);
      applyStimulus();
      fwd_stall_release = 2'b11;
      tick();
      checkOutput("release_all", 32'(fwd_stall_valid), 32'b00);
      applyStimulus();

      // Both slots wait on entry 7; one retire ends both.
      fwd_stall_alloc       = 1'b1;
      fwd_stall_alloc_entry = 4'd7;
      tick();
      tick();
      checkOutput("dup_valid", 32'(fwd_stall_valid), 32'b11);
      applyStimulus();
      lmem_wr_en_clear_mshr = 1'b1;
      mshr_i                = 4'd7;
      tick();
      checkOutput("dup_ended", 32'(fwd_stall_ended), 32'b11);
      fwd_stall_release = 2'b11;
      tick();
      checkOutput("rel_retire_valid", 32'(fwd_stall_valid), 32'b00);
      checkOutput("rel_retire_ended", 32'(fwd_stall_ended), 32'b00);
      applyStimulus();

      // Alloc in the same cycle as a retire of the same entry: not ended.
      fwd_stall_alloc       = 1'b1;
      fwd_stall_alloc_entry = 4'd4;
      lmem_wr_en_clear_mshr = 1'b1;
      mshr_i                = 4'd4;
      tick();
      checkOutput("alloc_retire_valid", 32'(fwd_stall_valid), 32'b01);
      checkOutput("alloc_retire_ended", 32'(fwd_stall_ended), 32'b00);
      fwd_stall_alloc = 1'b0;
      tick();
      checkOutput("later_retire_ended", 32'(fwd_stall_ended), 32'b01);
      applyStimulus();
      fwd_stall_release = 2'b01;
      tick();
      applyStimulus();

      // Flush walk over 4 sets x 2 ways.
      flush_start = 1'b1;
      tick();
      flush_start = 1'b0;
      checkOutput("fl_active", 32'(flush_active), 32'd1);
      checkOutput("fl_pos0", 32'({flush_set, flush_way}), 32'd0);
      flush_step = 1'b1;
      for (int k = 1; k < 8; k++) begin
         flush_start = (k == 3);
         tick();
         checkOutput($sformatf("fl_pos%0d", k), 32'({flush_set, flush_way}), 32'(k));
         checkOutput($sformatf("fl_nodone%0d", k), 32'(flush_done), 32'd0);
      end
      flush_start = 1'b0;
      tick();
      checkOutput("fl_done", 32'(flush_done), 32'd1);
      checkOutput("fl_last_pos", 32'({flush_set, flush_way}), 32'b111);
      flush_step = 1'b0;
      tick();
      checkOutput("fl_done_once", 32'(flush_done), 32'd0);
      checkOutput("fl_inactive", 32'(flush_active), 32'd0);
      checkOutput("fl_hold_pos", 32'({flush_set, flush_way}), 32'b111);

      // Reset in the middle of a walk with other state disturbed.
      flush_start = 1'b1;
      tick();
      flush_start = 1'b0;
      flush_step  = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      checkOutput("fl_mid_set2", 32'({flush_set, flush_way}), 32'b100);
      applyStimulus();
      add_mshr_entry        = 1'b1;
      set_evict_stall       = 1'b1;
      fwd_stall_alloc       = 1'b1;
      fwd_stall_alloc_entry = 4'd2;
      tick();
      applyStimulus();
      flush_step = 1'b1;
      rst        = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus();
      checkOutput("rst2_cnt",    32'(mshr_cnt), 32'd16);
      checkOutput("rst2_err",    32'(mshr_cnt_err), 32'd0);
      checkOutput("rst2_flags",  32'({ongoing_atomic, set_conflict, evict_stall}), 32'd0);
      checkOutput("rst2_valid",  32'({fwd_stall_valid, fwd_stall_ended, fwd_stall}), 32'd0);
      checkOutput("rst2_walker", 32'({flush_active, flush_done, flush_set, flush_way}), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
